// File: rtl/counter_pkg.sv
// Shared constants and clamp helper for the up/down counter family.
// Pure declarations: no state, no latency, no flow control.
package counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;

   localparam int CLAMP_W = 64;

   // Callers widen their operands to CLAMP_W and truncate the result back.
   function automatic logic [CLAMP_W-1:0] clamp_to_limit(
      input logic [CLAMP_W-1:0] value,
      input logic [CLAMP_W-1:0] lim
   );
      return (value > lim) ? lim : value;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: tick on every PRESCALE-th enabled cycle, combinational tick.
// No backpressure; enable=0 freezes the phase, clear/reset restart it.
module counter_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = enable && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with load, modulus, step and wrap/saturate; out and tc registered, one-edge latency, no backpressure.
// Optional COUNTER_PRESCALE_EN divides the enable by PRESCALE via counter_prescaler.
module updown_counter_mod
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int STEP_W   = 4,
   parameter int PRESCALE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              load,
   input  logic [WIDTH-1:0]  data,
   input  logic              up_down,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  limit,
   input  logic              mode_sat,
   output logic [WIDTH-1:0]  out,
   output logic              tc,
   output logic              at_max,
   output logic              at_min
);

   logic [WIDTH-1:0] out_q, out_d;
   logic             tc_q, tc_d;
   logic             step_en;
   logic [WIDTH:0]   step_x, lim_x, lim_p1, sum_w, diff_w;

`ifdef COUNTER_PRESCALE_EN
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (load),
      .tick   (step_en)
   );
`else
   assign step_en = enable;
`endif

   assign step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
   assign lim_x  = {1'b0, limit};
   assign lim_p1 = lim_x + 1'b1;
   assign sum_w  = {1'b0, out_q} + step_x;
   // MSB of diff_w is the sign: both operands are below 2**WIDTH.
   assign diff_w = {1'b0, out_q} - step_x;

   always_comb begin
      out_d = out_q;
      tc_d  = 1'b0;
      if (load) begin
         out_d = WIDTH'(clamp_to_limit(CLAMP_W'(data), CLAMP_W'(limit)));
      end else if (step_en && (step != '0)) begin
         if (up_down == DIR_UP) begin
            if (sum_w <= lim_x) begin
               out_d = sum_w[WIDTH-1:0];
            end else if (mode_sat == MODE_SAT) begin
               out_d = limit;
               tc_d  = (out_q != limit);
            end else begin
               out_d = WIDTH'(sum_w - lim_p1);
               tc_d  = 1'b1;
            end
         end else begin
            if (diff_w[WIDTH]) begin
               if (mode_sat == MODE_SAT) begin
                  out_d = '0;
                  tc_d  = (out_q != '0);
               end else begin
                  out_d = WIDTH'(diff_w + lim_p1);
                  tc_d  = 1'b1;
               end
            end else if (diff_w > lim_x) begin
               // Only reachable after limit was lowered below the count.
               out_d = limit;
            end else begin
               out_d = diff_w[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         out_q <= out_d;
         tc_q  <= tc_d;
      end
   end

   assign out    = out_q;
   assign tc     = tc_q;
   assign at_max = (out_q == limit);
   assign at_min = (out_q == '0);

   a_cfg : assert property (@(posedge clk) (PRESCALE >= 1) && (STEP_W <= WIDTH));

   // Wrap arithmetic is only defined while a single step fits in the modulus.
   a_step_range : assert property (@(posedge clk) disable iff (reset)
      (enable && !load && (mode_sat == MODE_WRAP)) |-> (step_x <= lim_p1));

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: directed vector table, prescaler sequence, randomized model comparison.
module tb_updown_counter_mod;

   localparam int W  = 8;
   localparam int SW = 4;
   localparam int PS = 4;

   logic          clk = 1'b0;
   logic          reset, enable, load, up_down, mode_sat;
   logic [W-1:0]  data, limit;
   logic [SW-1:0] step;
   logic [W-1:0]  out;
   logic          tc, at_max, at_min;

   int checks = 0;
   int errors = 0;

   int m_out, m_tc, m_ps;

   always #5 clk = ~clk;

   updown_counter_mod #(
      .WIDTH    (W),
      .STEP_W   (SW),
      .PRESCALE (PS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .load     (load),
      .data     (data),
      .up_down  (up_down),
      .step     (step),
      .limit    (limit),
      .mode_sat (mode_sat),
      .out      (out),
      .tc       (tc),
      .at_max   (at_max),
      .at_min   (at_min)
   );

   typedef struct packed {
      logic         rst, ld, en, ud, sat;
      logic [W-1:0] dat;
      logic [SW-1:0] stp;
      logic [W-1:0] lim;
      logic [W-1:0] e_out;
      logic         e_tc, e_max, e_min;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input bit r, l, e, ud, s, input int d, st, lim,
                               input int eo, input bit et, emx, emn);
      vec_t v;
      v.rst = r; v.ld = l; v.en = e; v.ud = ud; v.sat = s;
      v.dat = 8'(d); v.stp = 4'(st); v.lim = 8'(lim);
      v.e_out = 8'(eo); v.e_tc = et; v.e_max = emx; v.e_min = emn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: counting rules in plain integer arithmetic.
   task automatic model_edge();
      int s, d;
      bit fire;
      if (reset) begin
         m_out = 0; m_tc = 0; m_ps = 0;
      end else if (load) begin
         m_out = (int'(data) < int'(limit)) ? int'(data) : int'(limit);
         m_tc = 0; m_ps = 0;
      end else if (enable) begin
`ifdef COUNTER_PRESCALE_EN
         m_ps = (m_ps + 1) % PS;
         fire = (m_ps == 0);
`else
         fire = 1'b1;
`endif
         m_tc = 0;
         if (fire && step != 0) begin
            if (up_down) begin
               s = m_out + int'(step);
               if (s <= int'(limit)) m_out = s;
               else if (mode_sat) begin
                  m_tc = (m_out != int'(limit)) ? 1 : 0;
                  m_out = int'(limit);
               end else begin
                  m_out = (s - (int'(limit) + 1)) & 255;
                  m_tc = 1;
               end
            end else begin
               d = m_out - int'(step);
               if (d < 0) begin
                  if (mode_sat) begin
                     m_tc = (m_out != 0) ? 1 : 0;
                     m_out = 0;
                  end else begin
                     m_out = (d + int'(limit) + 1) & 255;
                     m_tc = 1;
                  end
               end else if (d > int'(limit)) m_out = int'(limit);
               else m_out = d;
            end
         end
      end else begin
         m_tc = 0;
      end
   endtask

   task automatic model_cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      chk({tag, " out"}, 32'(out), 32'(m_out));
      chk({tag, " tc"}, 32'(tc), 32'(m_tc));
      chk({tag, " at_max"}, 32'(at_max), (m_out == int'(limit)) ? 32'd1 : 32'd0);
      chk({tag, " at_min"}, 32'(at_min), (m_out == 0) ? 32'd1 : 32'd0);
   endtask

   task automatic drive(input bit r, l, e, ud, s, input int d, st, lim);
      reset = r; load = l; enable = e; up_down = ud; mode_sat = s;
      data = 8'(d); step = 4'(st); limit = 8'(lim);
   endtask

   initial begin
      int lim_r, stp_r;
      drive(1, 0, 0, 1, 0, 0, 1, 9);

`ifndef COUNTER_PRESCALE_EN
      // Up wrap, limit 9, step 1
      vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 9, 0, 0, 0, 1));
      for (int k = 1; k <= 12; k++)
         vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 9, k % 10, k == 10, (k % 10) == 9, (k % 10) == 0));
      // Down saturate from 0x0F by 4
      vecs.push_back(mk(0, 1, 0, 0, 1, 'h0F, 4, 'hFF, 'h0F, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 4, 'hFF, 'h0B, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 4, 'hFF, 'h07, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 4, 'hFF, 'h03, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 4, 'hFF, 'h00, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 4, 'hFF, 'h00, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 4, 'hFF, 'h00, 0, 0, 1));
      // Load clamp beats enable, reset beats load
      vecs.push_back(mk(0, 1, 1, 1, 0, 'h50, 1, 'h20, 'h20, 0, 1, 0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 'h50, 1, 'h20, 'h00, 0, 0, 1));
      // Wrap with step 3, then lowered limit on a down step
      vecs.push_back(mk(0, 1, 0, 1, 0, 9, 3, 10, 9, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 3, 10, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 8, 1, 10, 8, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 5, 5, 0, 1, 0));
      // Hold, then zero step
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 5, 5, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 5, 5, 0, 1, 0));
      // Saturating clip at max pulses tc only once
      vecs.push_back(mk(0, 1, 0, 1, 1, 'hFE, 4, 'hFF, 'hFE, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 4, 'hFF, 'hFF, 1, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 4, 'hFF, 'hFF, 0, 1, 0));
      // Lowering limit while idle does not clamp
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 4, 'h10, 'hFF, 0, 0, 0));
      // limit = 0
      vecs.push_back(mk(0, 1, 0, 1, 0, 3, 1, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v = vecs[i];
         drive(v.rst, v.ld, v.en, v.ud, v.sat, int'(v.dat), int'(v.stp), int'(v.lim));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d out", i), 32'(out), 32'(v.e_out));
         chk($sformatf("vec%0d tc", i), 32'(tc), 32'(v.e_tc));
         chk($sformatf("vec%0d at_max", i), 32'(at_max), 32'(v.e_max));
         chk($sformatf("vec%0d at_min", i), 32'(at_min), 32'(v.e_min));
      end
`else
      // Prescaled: out advances once per PS enabled cycles
      drive(1, 0, 0, 1, 0, 0, 1, 'hFF);
      @(posedge clk);
      #1;
      chk("ps reset out", 32'(out), 32'd0);
      for (int k = 1; k <= 6; k++) begin
         drive(0, 0, 1, 1, 0, 0, 1, 'hFF);
         @(posedge clk);
         #1;
         chk($sformatf("ps en%0d out", k), 32'(out), 32'(k / PS));
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1, 0, 0, 1, 'hFF);
         @(posedge clk);
         #1;
         chk($sformatf("ps gap%0d out", k), 32'(out), 32'd1);
      end
      for (int k = 7; k <= 8; k++) begin
         drive(0, 0, 1, 1, 0, 0, 1, 'hFF);
         @(posedge clk);
         #1;
         chk($sformatf("ps en%0d out", k), 32'(out), 32'(k / PS));
      end
      drive(0, 1, 1, 1, 0, 10, 1, 'hFF);
      @(posedge clk);
      #1;
      chk("ps load out", 32'(out), 32'd10);
      for (int k = 1; k <= 4; k++) begin
         drive(0, 0, 1, 1, 0, 0, 1, 'hFF);
         @(posedge clk);
         #1;
         chk($sformatf("ps post-load%0d out", k), 32'(out), (k == 4) ? 32'd11 : 32'd10);
      end
`endif

      // Randomized run against the reference model
      lim_r = 9;
      drive(1, 0, 0, 1, 0, 0, 1, lim_r);
      model_cycle("rnd reset");
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 15) == 0)
            lim_r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255));
         stp_r = int'($urandom_range(0, 15));
         mode_sat = 1'($urandom_range(0, 1));
         if (!mode_sat && stp_r > lim_r + 1) stp_r = lim_r + 1;
         reset   = ($urandom_range(0, 63) == 0);
         load    = ($urandom_range(0, 7) == 0);
         enable  = ($urandom_range(0, 3) != 0);
         up_down = 1'($urandom_range(0, 1));
         data    = 8'($urandom_range(0, 255));
         step    = 4'(stp_r);
         limit   = 8'(lim_r);
         model_cycle($sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
